host_i2c_target: RTL

- I2C target (slave) front-end for the HOST_SCL/HOST_SDA host link.
- Sits directly behind the top-level pads:
  - Converts host write transactions into a byte stream for the internal core.
  - Serves host reads from a byte stream supplied by the core.
  - Uses SCL clock stretching for flow control.
- The top level drives each pad open-drain: `pad = oe ? 1'b0 : 1'bz`.

---
 rtl/host_i2c_target.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/host_i2c_target.sv
// host_i2c_target: I2C target front-end for the HOST_SCL/HOST_SDA link.
// Filters the raw pad levels, decodes START/STOP, matches DEVICE_ADDR and
// moves bytes between the bus and the core rx/tx streams.
// Optional feature macro: HOST_I2C_STRETCH_EN enables SCL clock stretching;
// without it, a busy rx path NACKs and an empty tx path returns 8'hFF.
module host_i2c_target #(
  parameter logic [6:0]  DEVICE_ADDR  = 7'h55,
  parameter int unsigned FILTER_DEPTH = 3
) (
  input  logic       clock_sig,
  input  logic       reset_sig,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned BIT_W = 4;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_BIT, WR_ACK, RD_LOAD, RD_BIT, RD_ACK, IGNORE
  } state_t;

  // index 1 = SCL, index 0 = SDA
  logic [1:0]       meta_q, sync_q, filt_q, prev_q;
  logic [CNT_W-1:0] cnt_q [2];

  logic scl_f, sda_f, scl_rise_c, scl_fall_c, start_c, stop_c;

  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             rw_q, rw_d, first_q, first_d;
  logic             scl_oe_d, sda_oe_d, rx_first_d, rx_valid_d, tx_ready_d, busy_d;
  logic [7:0]       rx_data_d;

  // Two-flop synchronizer plus a level filter that needs FILTER_DEPTH agreeing samples
  always_ff @(posedge clock_sig) begin
    if (reset_sig) begin
      meta_q   <= 2'b11;
      sync_q   <= 2'b11;
      filt_q   <= 2'b11;
      prev_q   <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      meta_q <= {scl_i, sda_i};
      sync_q <= meta_q;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(FILTER_DEPTH - 1)) begin
          filt_q[i] <= sync_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign scl_f      = filt_q[1];
  assign sda_f      = filt_q[0];
  assign scl_rise_c = scl_f & ~prev_q[1];
  assign scl_fall_c = ~scl_f & prev_q[1];
  assign start_c    = scl_f & prev_q[0] & ~sda_f;
  assign stop_c     = scl_f & ~prev_q[0] & sda_f;

  // State and registered outputs
  always_ff @(posedge clock_sig) begin
    if (reset_sig) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= 8'h00;
      rw_q      <= 1'b0;
      first_q   <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'h00;
      rx_first  <= 1'b0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      rw_q      <= rw_d;
      first_q   <= first_d;
      scl_oe    <= scl_oe_d;
      sda_oe    <= sda_oe_d;
      rx_data   <= rx_data_d;
      rx_first  <= rx_first_d;
      rx_valid  <= rx_valid_d;
      tx_ready  <= tx_ready_d;
      busy      <= busy_d;
    end
  end

  // Next-state and output decode; START/STOP override every state
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rw_d       = rw_q;
    first_d    = first_q;
    scl_oe_d   = scl_oe;
    sda_oe_d   = sda_oe;
    rx_data_d  = rx_data;
    rx_first_d = rx_first;
    rx_valid_d = rx_valid & ~rx_ready;
    tx_ready_d = 1'b0;
    busy_d     = busy;

    if (start_c || stop_c) begin
      state_d   = start_c ? ADDR : IDLE;
      bit_cnt_d = '0;
      scl_oe_d  = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise_c && bit_cnt_q != BIT_W'(8)) begin
            shreg_d   = {shreg_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else if (scl_fall_c && bit_cnt_q == BIT_W'(8)) begin
            if (shreg_q[7:1] == DEVICE_ADDR) begin
              sda_oe_d = 1'b1;
              rw_d     = shreg_q[0];
              busy_d   = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall_c) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d = RD_LOAD;
            end else begin
              first_d = 1'b1;
              state_d = WR_BIT;
            end
          end
        end
        WR_BIT: begin
          if (scl_rise_c && bit_cnt_q != BIT_W'(8)) begin
            shreg_d   = {shreg_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else if (bit_cnt_q == BIT_W'(8) && (scl_fall_c || scl_oe)) begin
            if (!rx_valid) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              sda_oe_d   = 1'b1;
              scl_oe_d   = 1'b0;
              state_d    = WR_ACK;
            end else begin
`ifdef HOST_I2C_STRETCH_EN
              scl_oe_d = 1'b1;
`else
              sda_oe_d = 1'b0;
              state_d  = IGNORE;
`endif
            end
          end
        end
        WR_ACK: begin
          if (scl_fall_c) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WR_BIT;
          end
        end
        RD_LOAD: begin
          if (tx_valid) begin
            tx_ready_d = 1'b1;
            shreg_d    = tx_data;
            sda_oe_d   = ~tx_data[7];
            scl_oe_d   = 1'b0;
            bit_cnt_d  = BIT_W'(1);
            state_d    = RD_BIT;
          end else begin
`ifdef HOST_I2C_STRETCH_EN
            scl_oe_d = 1'b1;
`else
            shreg_d   = 8'hFF;
            sda_oe_d  = 1'b0;
            bit_cnt_d = BIT_W'(1);
            state_d   = RD_BIT;
`endif
          end
        end
        RD_BIT: begin
          if (scl_fall_c) begin
            if (bit_cnt_q == BIT_W'(8)) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d  = ~shreg_q[6];
              shreg_d   = {shreg_q[6:0], 1'b1};
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
        RD_ACK: begin
          if (scl_rise_c && sda_f) begin
            state_d = IGNORE;
          end else if (scl_fall_c) begin
            state_d = RD_LOAD;
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
